ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It is the opposite direction of the existing ps2_keyboard receiver: it sends one command byte to the keyboard, for example 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable). It owns the open-drain drive of ps2_clk/ps2_data during a transmission and tells the receiver to ignore the bus while it does so. It sits beside ps2_keyboard in top and shares the same physical pins through tri-state buffers in top.

Parameters:
INHIBIT_CYCLES, 12000, clk cycles ps2_clk is held low before the request (120 us at 100 MHz; minimum 100 us).
TIMEOUT_CYCLES, 2000000, maximum clk cycles from clock release to ACK seen (20 ms at 100 MHz).
FILTER_LEN, 8, consecutive equal synchronised samples required to accept a new ps2_clk level.

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high
tx_valid  in  1  request to send tx_data
tx_data  in  8  command byte
tx_ready  out  1  high in IDLE only; a byte is accepted when tx_valid && tx_ready
ps2_clk_in  in  1  raw ps2_clk pin level
ps2_data_in  in  1  raw ps2_data pin level
ps2_clk_oe  out  1  1 = drive ps2_clk low, 0 = release
ps2_data_oe  out  1  1 = drive ps2_data low, 0 = release
busy  out  1  high in every state except IDLE; ps2_keyboard must ignore edges while busy
done  out  1  one-cycle pulse: frame sent and device ACK seen
error  out  1  one-cycle pulse: timeout or missing ACK

Behaviour:
- Reset values: state=IDLE; ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, error=0; tx_ready=1 in the cycle after reset is released. Reset in the middle of a frame releases both lines in the next cycle with no error pulse.
- Input path: 2-FF synchroniser on each pin, then a FILTER_LEN glitch filter on clk only. A falling edge (fall) is a 1→0 change of the filtered level.
- Handshake: accepting a byte latches tx_data into shreg[7:0] and sets parity = ~^tx_data (odd parity). A tx_valid arriving while not ready is ignored; nothing is queued.
- States:
  - IDLE: tx_ready=1. On accept → INHIBIT and clear the counter.
  - INHIBIT: clk_oe=1, data_oe=0. When the counter reaches INHIBIT_CYCLES-1 → REQ.
  - REQ: one cycle with clk_oe=1, data_oe=1 (start bit). Then → BITS with clk_oe=0, bitcnt=0, timeout counter cleared.
  - BITS: on each fall, drive the next bit: bitcnt 0..7 drives shreg[bitcnt], bitcnt 8 drives parity, bitcnt 9 drives the stop bit (data_oe=0). data_oe = ~bit. bitcnt increments per fall; after bitcnt 9 is driven → ACK.
  - ACK: on the next fall, sample the synchronised data. 0 → WAIT_IDLE with ack=1; 1 → WAIT_IDLE with ack=0.
  - WAIT_IDLE: wait for filtered clk=1 and sync data=1, then → IDLE and pulse done if ack, otherwise pulse error.
- Timeout: the timeout counter runs in BITS, ACK and WAIT_IDLE. When it reaches TIMEOUT_CYCLES-1: release both lines, pulse error, → IDLE.
- Latency: data_oe changes exactly 1 clk after the fall is detected, giving about 2+FILTER_LEN+1 clk from the pin edge. That is well within the 50 us low phase.
- Simultaneous events: a fall and the timeout in the same cycle → the timeout wins. done and error are never high together.
- Counter widths: ceil(log2) of the respective parameter; bitcnt is 4 bits.

Decomposition:
- Shared package ps2_pkg:
  - state enum (IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE)
  - command constants: CMD_SET_LED=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF, RSP_ACK=8'hFA
  - bit-index constants: PARITY_IDX=8, STOP_IDX=9
- One sub-module, ps2_line_filter: synchroniser plus glitch filter plus fall detect. It is reused later by ps2_keyboard.

Test Plan:
- Send 0xED with a device model clocking at 40 us per bit and ACKing. Require:
  - clk_oe low for 12000 cycles;
  - data bits sent LSB first are 1,0,1,1,0,1,1,1, then parity=1, then stop released;
  - done pulses once and tx_ready returns.
- Send 0xF4. Require parity bit = 0. Send 0x01: parity bit = 0. Send 0x00: parity bit = 1.
- Device never clocks after REQ. Require error to pulse at TIMEOUT_CYCLES after clock release, both oe=0, state IDLE, done never asserted.
- Device holds data high on the 11th fall (no ACK). Require error to pulse once the bus is idle, with no done.
- Assert reset mid-frame after the 4th bit. Require ps2_clk_oe=ps2_data_oe=0 the next cycle, no error, tx_ready=1. A following send of 0xFF completes normally.
- Inject 3-cycle glitches on ps2_clk during BITS. Require no extra bit advance; frame received intact. Hold tx_valid while busy: require exactly one frame sent.

Source files
------------

// File: rtl/ps2_pkg.sv
// PS/2 host-side shared definitions: FSM states, command bytes,
// frame bit indices and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    BITS,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RSP_ACK     = 8'hFA;

  localparam logic [3:0] PARITY_IDX = 4'd8;
  localparam logic [3:0] STOP_IDX   = 4'd9;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pin conditioning: 2-FF synchronisers on clk/data, glitch filter on clk.
// Ports: clk, reset, clk_pin/data_pin raw -> clk_filt, data_sync, fall pulse.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_pin,
  input  logic data_pin,
  output logic clk_filt,
  output logic data_sync,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  logic [1:0]    clk_meta;
  logic [1:0]    data_meta;
  logic [CW-1:0] cnt;

  assign data_sync = data_meta[1];

  // A new clk level is taken only after FILTER_LEN samples in a row
  // disagree with the current filtered level.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta  <= 2'b11;
      data_meta <= 2'b11;
      clk_filt  <= 1'b1;
      cnt       <= '0;
      fall      <= 1'b0;
    end else begin
      clk_meta  <= {clk_meta[0], clk_pin};
      data_meta <= {data_meta[0], data_pin};
      fall      <= 1'b0;
      if (clk_meta[1] == clk_filt) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt      <= '0;
        clk_filt <= clk_meta[1];
        fall     <= clk_filt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter with open-drain line control.
// Ports: tx_valid/tx_data/tx_ready in, pins in, *_oe out, busy/done/error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int IW = $clog2(INHIBIT_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] ICNT_MAX = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TCNT_MAX = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_t    state;
  logic [IW-1:0] icnt;
  logic [TW-1:0] tcnt;
  logic [3:0]    bitcnt;
  logic [7:0]    shreg;
  logic          parity;
  logic          ack;
  logic          clk_filt;
  logic          data_sync;
  logic          fall;
  logic          tx_bit;
  logic          tmo;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filt (
    .clk      (clk),
    .reset    (reset),
    .clk_pin  (ps2_clk_in),
    .data_pin (ps2_data_in),
    .clk_filt (clk_filt),
    .data_sync(data_sync),
    .fall     (fall)
  );

  assign tmo = (tcnt == TCNT_MAX);

  // Bit driven on the next fall; the stop bit is a released line.
  always_comb begin
    tx_bit = 1'b1;
    unique case (1'b1)
      (bitcnt < PARITY_IDX):  tx_bit = shreg[bitcnt[2:0]];
      (bitcnt == PARITY_IDX): tx_bit = parity;
      default:                tx_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      icnt        <= '0;
      tcnt        <= '0;
      bitcnt      <= '0;
      shreg       <= '0;
      parity      <= 1'b0;
      ack         <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tx_valid) begin
            state      <= INHIBIT;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            icnt       <= '0;
            shreg      <= tx_data;
            parity     <= odd_parity(tx_data);
          end
        end
        INHIBIT: begin
          if (icnt == ICNT_MAX) begin
            state       <= REQ;
            ps2_data_oe <= 1'b1;
          end else begin
            icnt <= icnt + 1'b1;
          end
        end
        REQ: begin
          state      <= BITS;
          ps2_clk_oe <= 1'b0;
          bitcnt     <= '0;
          tcnt       <= '0;
        end
        BITS, ACK, WAIT_IDLE: begin
          tcnt <= tcnt + 1'b1;
          if (tmo) begin
            // Timeout outranks any fall seen in the same cycle.
            state       <= IDLE;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            error       <= 1'b1;
          end else if (state == BITS) begin
            if (fall) begin
              ps2_data_oe <= ~tx_bit;
              bitcnt      <= bitcnt + 1'b1;
              if (bitcnt == STOP_IDX) begin
                state <= ACK;
              end
            end
          end else if (state == ACK) begin
            if (fall) begin
              ack   <= ~data_sync;
              state <= WAIT_IDLE;
            end
          end else if (clk_filt && data_sync) begin
            state    <= IDLE;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= ack;
            error    <= ~ack;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device model on the pins, table and random frames,
// plus timeout, mid-frame reset and held-valid sequences.
module tb_ps2_host_tx;

  localparam int INH = 64;
  localparam int TMO = 1500;
  localparam int FL  = 4;
  localparam int H   = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       clk_oe;
  logic       data_oe;
  logic       busy;
  logic       done;
  logic       error;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  int checks = 0;
  int passed = 0;
  int n_done = 0;
  int n_err = 0;
  int n_both = 0;
  int n_acc = 0;

  assign ps2_clk_in  = dev_clk & ~clk_oe;
  assign ps2_data_in = dev_data & ~data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (clk_oe),
    .ps2_data_oe(data_oe),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) n_done <= n_done + 1;
    if (error) n_err <= n_err + 1;
    if (done && error) n_both <= n_both + 1;
    if (tx_valid && tx_ready && !reset) n_acc <= n_acc + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_parity(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += (d >> i) & 1;
    return (ones % 2 == 0);
  endfunction

  task automatic send(input logic [7:0] d);
    int k = 0;
    while (!tx_ready && k < 5000) begin
      tick();
      k++;
    end
    chk("ready_wait", k < 5000, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  // Keyboard model: waits for the request, then clocks nfall falls,
  // recording the line level at the end of each low phase.
  task automatic device(input int nfall, input bit do_ack, input bit gl,
                        output logic [10:0] bits, output int inh);
    int k = 0;
    bits = '1;
    inh  = 0;
    while (!(ps2_clk_in && !ps2_data_in) && k < INH + 100) begin
      if (clk_oe && !data_oe) inh++;
      tick();
      k++;
    end
    chk("req_seen", k < INH + 100, 1);
    bits[0] = ps2_data_in;
    for (int f = 1; f <= nfall; f++) begin
      for (int i = 0; i < H; i++) begin
        if (f == 11 && do_ack && i == H / 2) dev_data = 1'b0;
        if (gl && i == 10) dev_clk = 1'b0;
        if (gl && i == 13) dev_clk = 1'b1;
        tick();
      end
      dev_clk = 1'b0;
      repeat (H) tick();
      if (f <= 10) bits[f] = ps2_data_in;
      dev_clk = 1'b1;
    end
    if (nfall == 11) begin
      repeat (H) tick();
      dev_data = 1'b1;
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input bit ack, input bit gl,
                           input logic exp_par, input bit exp_ok,
                           input string tag);
    logic [10:0] bits;
    logic [7:0]  exp_d;
    int inh, k, d0, e0;
    d0 = n_done;
    e0 = n_err;
    send(d);
    device(11, ack, gl, bits, inh);
    k = 0;
    while (busy && k < 200) begin
      tick();
      k++;
    end
    tick();
    exp_d = '0;
    for (int i = 0; i < 8; i++) exp_d[i] = (d / (1 << i)) % 2;
    chk({tag, "_end"}, k < 200, 1);
    chk({tag, "_inhibit"}, inh, INH);
    chk({tag, "_start"}, bits[0], 0);
    chk({tag, "_data"}, bits[8:1], exp_d);
    chk({tag, "_parity"}, bits[9], exp_par);
    chk({tag, "_stop"}, bits[10], 1);
    chk({tag, "_done"}, n_done - d0, exp_ok ? 1 : 0);
    chk({tag, "_error"}, n_err - e0, exp_ok ? 0 : 1);
    chk({tag, "_ready"}, tx_ready, 1);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         gl;
    logic       par;
    bit         ok;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [10:0] bits;
    logic [7:0]  d;
    int inh, k, d0, e0, a0;

    vt[0] = '{8'hED, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[1] = '{8'hF4, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[2] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[3] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[4] = '{8'hFA, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[5] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b1};

    repeat (3) tick();
    chk("rst_clk_oe", clk_oe, 0);
    chk("rst_data_oe", data_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    reset = 1'b0;
    tick();
    chk("rst_ready", tx_ready, 1);

    for (int v = 0; v < 6; v++)
      run_frame(vt[v].data, vt[v].ack, vt[v].gl, vt[v].par, vt[v].ok,
                $sformatf("vec%0d", v));

    for (int r = 0; r < 4; r++) begin
      d = 8'($urandom_range(0, 255));
      run_frame(d, 1'b1, 1'($urandom_range(0, 1)), model_parity(d), 1'b1,
                $sformatf("rnd%0d", r));
    end

    d0 = n_done;
    e0 = n_err;
    send(8'hF4);
    device(0, 1'b0, 1'b0, bits, inh);
    k = 0;
    while (!error && k < TMO + 50) begin
      tick();
      k++;
    end
    chk("tmo_cycles", k, TMO);
    chk("tmo_clk_oe", clk_oe, 0);
    chk("tmo_data_oe", data_oe, 0);
    chk("tmo_busy", busy, 0);
    chk("tmo_ready", tx_ready, 1);
    tick();
    chk("tmo_done", n_done - d0, 0);
    chk("tmo_error", n_err - e0, 1);

    e0 = n_err;
    d  = 8'h3C;
    send(d);
    device(4, 1'b0, 1'b0, bits, inh);
    repeat (3) tick();
    chk("mid_bits", bits[4:1], d[3:0]);
    chk("mid_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    chk("mid_clk_oe", clk_oe, 0);
    chk("mid_data_oe", data_oe, 0);
    chk("mid_error", error, 0);
    chk("mid_ready", tx_ready, 1);
    reset = 1'b0;
    tick();
    tick();
    chk("mid_err_cnt", n_err - e0, 0);
    run_frame(8'hFF, 1'b1, 1'b0, model_parity(8'hFF), 1'b1, "after_rst");

    a0 = n_acc;
    d0 = n_done;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    tick();
    device(11, 1'b1, 1'b0, bits, inh);
    k = 0;
    while (!done && k < 200) begin
      tick();
      k++;
    end
    tx_valid = 1'b0;
    repeat (3) tick();
    chk("hold_accepts", n_acc - a0, 1);
    chk("hold_done", n_done - d0, 1);
    chk("hold_data", bits[8:1], 8'hA5);
    chk("hold_parity", bits[9], model_parity(8'hA5));
    chk("hold_busy", busy, 0);

    chk("done_error_overlap", n_both, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
